// File: rtl/video_mode_selector.sv
// rtl/video_mode_selector.sv - debounced next/prev video mode selection with safe pipeline reset sequencing
`ifndef MODE_1080p
`define MODE_1080p 8'h01
`endif
`ifndef MODE_1080i
`define MODE_1080i 8'h02
`endif
`ifndef MODE_720p
`define MODE_720p 8'h03
`endif
`ifndef MODE_480p
`define MODE_480p 8'h04
`endif
`ifndef MODE_480i
`define MODE_480i 8'h05
`endif

module video_mode_selector #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned HOLDOFF_CYCLES  = 1024,
   parameter int unsigned RESET_INDEX     = 2
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       button_next,
   input  logic       button_prev,
   input  logic       pll_locked,
   output logic [7:0] mode_out,
   output logic [2:0] mode_index,
   output logic       pipeline_reset_n,
   output logic       busy
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);
   localparam logic [2:0]    RST_IDX   = 3'(RESET_INDEX);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_HOLD      = 2'd1;
   localparam logic [1:0] S_WAIT_LOCK = 2'd2;

   function automatic logic [7:0] mode_code(input logic [2:0] idx);
      case (idx)
         3'd0:    return `MODE_1080p;
         3'd1:    return `MODE_1080i;
         3'd2:    return `MODE_720p;
         3'd3:    return `MODE_480p;
         3'd4:    return `MODE_480i;
         default: return `MODE_720p;
      endcase
   endfunction

   // bit 0 = next, bit 1 = prev, bit 2 = pll lock
   logic [2:0] sync1_q, sync2_q;
   logic [1:0] req_pulse;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {pll_locked, button_prev, button_next};
         sync2_q <= sync1_q;
      end
   end

   for (genvar i = 0; i < 2; i++) begin : g_deb
      logic [DW-1:0] cnt_q, cnt_d;
      logic          lvl_q, lvl_d;
      logic          pulse_q;

      always_comb begin
         cnt_d = cnt_q;
         lvl_d = lvl_q;
         if (sync2_q[i] == lvl_q) begin
            cnt_d = '0;
         end else if (cnt_q >= DEB_LAST) begin
            lvl_d = ~lvl_q;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + DW'(1);
         end
      end

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            pulse_q <= 1'b0;
         end else begin
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            pulse_q <= lvl_d & ~lvl_q;
         end
      end

      assign req_pulse[i] = pulse_q;
   end

   logic [1:0]    state_q, state_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    mode_q, mode_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          prst_q, prst_d;
   logic          busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      mode_d  = mode_q;
      hold_d  = hold_q;
      prst_d  = prst_q;
      busy_d  = busy_q;
      case (state_q)
         S_IDLE: begin
            // simultaneous next+prev cancel each other
            if (req_pulse[0] ^ req_pulse[1]) begin
               if (req_pulse[0]) idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
               else              idx_d = (idx_q == 3'd0) ? 3'd4 : idx_q - 3'd1;
               mode_d  = mode_code(idx_d);
               hold_d  = '0;
               prst_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (hold_q == HOLD_LAST) state_d = S_WAIT_LOCK;
            else                     hold_d  = hold_q + HW'(1);
         end
         S_WAIT_LOCK: begin
            if (sync2_q[2]) begin
               state_d = S_IDLE;
               prst_d  = 1'b1;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_WAIT_LOCK;
            prst_d  = 1'b0;
            busy_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_WAIT_LOCK;
         idx_q   <= RST_IDX;
         mode_q  <= mode_code(RST_IDX);
         hold_q  <= '0;
         prst_q  <= 1'b0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         mode_q  <= mode_d;
         hold_q  <= hold_d;
         prst_q  <= prst_d;
         busy_q  <= busy_d;
      end
   end

   assign mode_out         = mode_q;
   assign mode_index       = idx_q;
   assign pipeline_reset_n = prst_q;
   assign busy             = busy_q;

endmodule

// File: tb/tb_video_mode_selector.sv
// tb/tb_video_mode_selector.sv - scoreboard bench for video_mode_selector
module tb_video_mode_selector;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       button_next = 1'b0;
   logic       button_prev = 1'b0;
   logic       pll_locked = 1'b1;
   logic [7:0] mode_out;
   logic [2:0] mode_index;
   logic       pipeline_reset_n;
   logic       busy;

   video_mode_selector #(
      .DEBOUNCE_CYCLES(4),
      .HOLDOFF_CYCLES (8),
      .RESET_INDEX    (2)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .button_next     (button_next),
      .button_prev     (button_prev),
      .pll_locked      (pll_locked),
      .mode_out        (mode_out),
      .mode_index      (mode_index),
      .pipeline_reset_n(pipeline_reset_n),
      .busy            (busy)
   );

   always #5 clock = ~clock;

   logic [7:0] codes [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
   logic [7:0] exp_q [$];
   logic [7:0] last_mode;
   logic       mon_en = 1'b0;
   int         checks = 0;
   int         errors = 0;
   int         low_cnt = 0;
   int         cur_idx = 2;

   // every change of mode_out must match the next queued expectation
   always @(negedge clock) begin
      if (!pipeline_reset_n) low_cnt++;
      if (mon_en && mode_out !== last_mode) begin
         logic [7:0] exp;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: mode_out=%h, no change expected", mode_out);
         end else begin
            exp = exp_q.pop_front();
            if (mode_out !== exp) begin
               errors++;
               $display("FAIL mode_change: mode_out=%h expected %h", mode_out, exp);
            end
         end
         checks++;
         if (pipeline_reset_n !== 1'b0) begin
            errors++;
            $display("FAIL reset_with_change: pipeline_reset_n=%b expected 0", pipeline_reset_n);
         end
         last_mode = mode_out;
      end
   end

   function automatic int step(input int idx, input bit fwd);
      if (fwd) return (idx == 4) ? 0 : idx + 1;
      return (idx == 0) ? 4 : idx - 1;
   endfunction

   task automatic wait_idle(input int budget, output int cycles);
      cycles = 0;
      while (!(busy === 1'b0 && pipeline_reset_n === 1'b1) && cycles < budget) begin
         @(negedge clock);
         cycles++;
      end
      checks++;
      if (cycles >= budget) begin
         errors++;
         $display("FAIL idle_timeout: busy=%b pipeline_reset_n=%b after %0d cycles", busy, pipeline_reset_n, cycles);
      end
   endtask

   task automatic press(input logic n, input logic p, input int hold);
      int c;
      button_next = n;
      button_prev = p;
      repeat (hold) @(negedge clock);
      button_next = 1'b0;
      button_prev = 1'b0;
      wait_idle(200, c);
      repeat (8) @(negedge clock);
   endtask

   task automatic check_index(input string name, input int idx);
      checks++;
      if (mode_index !== 3'(idx) || mode_out !== codes[idx]) begin
         errors++;
         $display("FAIL %s: index=%0d mode=%h expected index=%0d mode=%h", name, mode_index, mode_out, idx, codes[idx]);
      end
   endtask

   task automatic test_reset();
      int c;
      reset_n = 1'b0;
      pll_locked = 1'b1;
      repeat (3) @(negedge clock);
      checks++;
      if (mode_index !== 3'd2 || mode_out !== 8'h03 || pipeline_reset_n !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: idx=%0d mode=%h prst=%b busy=%b expected 2/03/0/1", mode_index, mode_out, pipeline_reset_n, busy);
      end
      reset_n = 1'b1;
      c = 0;
      while (pipeline_reset_n !== 1'b1 && c < 50) begin
         @(negedge clock);
         c++;
      end
      checks++;
      if (c != 3) begin
         errors++;
         $display("FAIL reset_release_latency: %0d cycles expected 3", c);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_after_lock: busy=%b expected 0", busy);
      end
      last_mode = mode_out;
      mon_en = 1'b1;
      cur_idx = 2;
   endtask

   task automatic test_next_single();
      low_cnt = 0;
      cur_idx = step(cur_idx, 1);
      exp_q.push_back(codes[cur_idx]);
      press(1'b1, 1'b0, 10);
      check_index("next_single", cur_idx);
      checks++;
      if (low_cnt < 8) begin
         errors++;
         $display("FAIL reset_low_time: %0d cycles expected >=8", low_cnt);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 3; i++) begin
         cur_idx = step(cur_idx, 1);
         exp_q.push_back(codes[cur_idx]);
         press(1'b1, 1'b0, 10);
         check_index("wrap_next", cur_idx);
      end
      for (int i = 0; i < 2; i++) begin
         cur_idx = step(cur_idx, 0);
         exp_q.push_back(codes[cur_idx]);
         press(1'b0, 1'b1, 10);
         check_index("wrap_prev", cur_idx);
      end
   endtask

   task automatic test_glitch_and_both();
      low_cnt = 0;
      press(1'b1, 1'b0, 3);
      repeat (10) @(negedge clock);
      check_index("glitch", cur_idx);
      press(1'b1, 1'b1, 10);
      repeat (10) @(negedge clock);
      check_index("both_buttons", cur_idx);
      checks++;
      if (low_cnt != 0) begin
         errors++;
         $display("FAIL no_switch_reset: pipeline_reset_n low %0d cycles expected 0", low_cnt);
      end
   endtask

   task automatic test_pll_unlocked();
      int  c;
      bit  bad = 0;
      pll_locked = 1'b0;
      cur_idx = step(cur_idx, 1);
      exp_q.push_back(codes[cur_idx]);
      button_next = 1'b1;
      repeat (10) @(negedge clock);
      button_next = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (pipeline_reset_n !== 1'b0 || busy !== 1'b1) bad = 1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL unlocked_hold: prst=%b busy=%b expected 0/1 while unlocked", pipeline_reset_n, busy);
      end
      check_index("unlocked_index", cur_idx);
      pll_locked = 1'b1;
      wait_idle(20, c);
      checks++;
      if (c != 3) begin
         errors++;
         $display("FAIL lock_release_latency: %0d cycles expected 3", c);
      end
      repeat (4) @(negedge clock);
   endtask

   task automatic test_busy_discard_and_abort();
      bit bad = 0;
      cur_idx = step(cur_idx, 1);
      exp_q.push_back(codes[cur_idx]);
      button_next = 1'b1;
      repeat (2) @(negedge clock);
      button_prev = 1'b1;
      repeat (10) @(negedge clock);
      button_next = 1'b0;
      button_prev = 1'b0;
      press(1'b0, 1'b0, 1);
      check_index("request_in_hold", cur_idx);

      cur_idx = step(cur_idx, 1);
      exp_q.push_back(codes[cur_idx]);
      button_next = 1'b1;
      repeat (8) @(negedge clock);
      button_next = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if (busy !== 1'b1 || mode_out !== codes[cur_idx]) begin
         errors++;
         $display("FAIL pre_abort: busy=%b mode=%h expected 1/%h", busy, mode_out, codes[cur_idx]);
      end
      mon_en = 1'b0;
      pll_locked = 1'b0;
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      cur_idx = 2;
      check_index("abort_reset", cur_idx);
      reset_n = 1'b1;
      repeat (10) begin
         @(negedge clock);
         if (busy !== 1'b1 || pipeline_reset_n !== 1'b0 || mode_index !== 3'd2) bad = 1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL abort_wait_lock: busy=%b prst=%b idx=%0d expected 1/0/2", busy, pipeline_reset_n, mode_index);
      end
      last_mode = mode_out;
      mon_en = 1'b1;
      pll_locked = 1'b1;
      press(1'b0, 1'b0, 1);
      check_index("after_abort", cur_idx);
   endtask

   initial begin
      test_reset();
      test_next_single();
      test_wrap();
      test_glitch_and_both();
      test_pll_unlocked();
      test_busy_discard_and_abort();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expected changes never seen", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
